uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
- Serial transmit stage sitting directly downstream of the CPU-side register file. It consumes bytes written to the data register and the baud-rate divisor value, and drives the TX pin.
- Contains a one-byte holding buffer, a shift register and a bit-period counter.
- Produces the status bits (holding-register empty, transmitter idle, overrun) and a frame-done pulse. The status register and interrupt logic consume these.
- Frame format is fixed at 8N1, LSB first.

Parameters:
- DATA_BITS, 8, data bits per frame.
- DIV_W, 8, width of the baud divisor input.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- NRST  input  1  asynchronous, active-low reset.
- EN  input  1  transmitter enable (from status register bit 0 inverted sense handled upstream; 1 = run).
- DIVISOR  input  DIV_W  bit period minus one, in CLK cycles.
- LOAD  input  1  one-cycle write strobe for the data register (register select & ~NW).
- DIN  input  DATA_BITS  byte to transmit, sampled when LOAD=1.
- CLR_OVR  input  1  clears the sticky overrun flag.
- TX  output  1  serial line out, idle high.
- TXE  output  1  holding buffer empty.
- TXIDLE  output  1  shifter idle and holding buffer empty.
- OVR  output  1  sticky: LOAD arrived while holding buffer full.
- DONE  output  1  one-cycle pulse at end of each stop bit.

Behaviour:
- Reset (NRST=0, asynchronous):
  - Outputs: TX=1, TXE=1, TXIDLE=1, OVR=0, DONE=0.
  - State IDLE, bit counter 0, baud counter 0, holding buffer cleared.
  - Deassertion is clean at any point; a frame in progress is aborted and TX returns high immediately.
- Holding buffer:
  - LOAD with TXE=1 captures DIN at that edge; TXE=0 from the next cycle.
  - LOAD with TXE=0 is dropped; OVR=1 from the next cycle.
  - OVR stays 1 until CLR_OVR=1. If CLR_OVR and an overrunning LOAD occur in the same cycle, set wins.
- States (uart_pkg::tx_state_t): IDLE, START, DATA, STOP.
- IDLE:
  - TX=1.
  - If the buffer is full and EN=1, the next edge moves the buffer into the shifter, sets TXE=1, enters START and drives TX=0.
  - The latency from the LOAD edge to TX falling is 1 cycle when idle.
- Bit period:
  - Each bit lasts DIVISOR+1 cycles. DIVISOR=0 gives 1 cycle per bit.
  - The baud counter loads DIVISOR at each bit start and counts down to 0, then the bit ends.
  - DIVISOR changes take effect at the next bit boundary only.
- START: after one bit period, enter DATA and drive TX = shifter[0].
- DATA:
  - Shift right each bit period; bit index counts 0..DATA_BITS-1.
  - After bit DATA_BITS-1, enter STOP with TX=1.
- STOP: after one bit period:
  - DONE=1 for exactly one cycle.
  - If the buffer is full and EN=1, go directly to START with no idle cycle, giving back-to-back frames.
  - Otherwise go to IDLE.
- EN=0 mid-frame: the baud counter and state freeze, and TX holds its current level. Resuming continues the same bit with the remaining count. EN=0 in IDLE prevents a new frame from starting.
- TXIDLE = (state==IDLE) & TXE.
- Frame length is 10*(DIVISOR+1) cycles. All counters are unsigned and never wrap outside the ranges above.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum;
  - DATA_BITS_DEF=8;
  - STOP_LEVEL=1'b1 and IDLE_LEVEL=1'b1 constants.
- One sub-module, uart_baud_counter:
  - inputs: CLK, NRST, EN, reload strobe, DIVISOR;
  - output: bit_end pulse (counter==0 & EN).
- The FSM, shifter and holding buffer stay in uart_tx_engine.

Test Plan:
- Reset mid-frame: DIVISOR=3, LOAD 8'hA5, assert NRST=0 during bit 4 -> TX=1, TXE=1, TXIDLE=1 immediately. No DONE is generated.
- Single frame: DIVISOR=3, LOAD 8'hA5 -> TX falls 1 cycle after the LOAD edge. The line sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. DONE pulses once, at cycle 40 after TX falls.
- Back-to-back: DIVISOR=0, LOAD 8'h00 then LOAD 8'hFF while the first is shifting -> 20 contiguous bit cycles with no idle gap. There are two DONE pulses, 10 cycles apart, and TXE=1 throughout the second frame.
- Overrun: with the shifter busy and the buffer full, LOAD 8'h55 -> OVR=1 and the byte is never sent. CLR_OVR -> OVR=0. CLR_OVR together with a new overrun -> OVR stays 1.
- Enable freeze: DIVISOR=7, drop EN for 20 cycles during a data bit -> that bit's length is 8+20 cycles and the rest of the frame is unchanged. EN=0 with a byte loaded while idle -> TX stays 1 until EN=1.
- Divisor change: change DIVISOR from 1 to 5 in the middle of bit 2 -> bit 2 keeps 2 cycles and bits 3 onward last 6 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
// The frame is fixed 8N1, LSB first.
package uart_pkg;

    localparam int   DATA_BITS_DEF = 8;
    localparam logic STOP_LEVEL    = 1'b1;
    localparam logic IDLE_LEVEL    = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: loads DIVISOR at each bit start and flags the last cycle of the bit.
// Holding EN low freezes the count, so a paused bit resumes with its remaining cycles.
module uart_baud_counter #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             EN,
    input  logic             reload,
    input  logic [DIV_W-1:0] DIVISOR,
    output logic             bit_end
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] count;

    // DIVISOR is only sampled on reload, so a change mid-bit waits for the boundary.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            count <= '0;
        end else if (reload) begin
            count <= DIVISOR;
        end else if (EN && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign bit_end = EN && (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 serial transmitter: one-byte holding buffer, shift register and framing FSM.
// Produces the TX line plus TXE / TXIDLE / OVR status and a DONE pulse per frame.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DIV_W     = 8
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 EN,
    input  logic [DIV_W-1:0]     DIVISOR,
    input  logic                 LOAD,
    input  logic [DATA_BITS-1:0] DIN,
    input  logic                 CLR_OVR,
    output logic                 TX,
    output logic                 TXE,
    output logic                 TXIDLE,
    output logic                 OVR,
    output logic                 DONE,
    output tx_state_t            state_dbg
);

    localparam int                BIDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE = {{(BIDX_W-1){1'b0}}, 1'b1};

    tx_state_t              state, state_nxt;
    logic [DATA_BITS-1:0]   shifter, shifter_nxt;
    logic [BIDX_W-1:0]      bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0]   hold_data;
    logic                   hold_full;
    logic                   ovr;
    logic                   take;
    logic                   reload;
    logic                   bit_end;

    uart_baud_counter #(
        .DIV_W (DIV_W)
    ) u_baud (
        .CLK     (CLK),
        .NRST    (NRST),
        .EN      (EN),
        .reload  (reload),
        .DIVISOR (DIVISOR),
        .bit_end (bit_end)
    );

    // Write handshake: LOAD is a single-cycle strobe with no back-pressure. It is
    // accepted only while TXE=1; a LOAD seen with TXE=0 is discarded and sets OVR.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (LOAD && !hold_full) begin
            hold_data <= DIN;
            hold_full <= 1'b1;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    // A dropped write in the same cycle as CLR_OVR keeps the flag set.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            ovr <= 1'b0;
        end else if (LOAD && hold_full) begin
            ovr <= 1'b1;
        end else if (CLR_OVR) begin
            ovr <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state   <= IDLE;
            shifter <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            shifter <= shifter_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shifter_nxt = shifter;
        bit_idx_nxt = bit_idx;
        take        = 1'b0;
        reload      = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full && EN) begin
                    take      = 1'b1;
                    reload    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    reload      = 1'b1;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    reload = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        shifter_nxt = shifter >> 1;
                        bit_idx_nxt = bit_idx + BIDX_ONE;
                    end
                end
            end
            STOP: begin
                // bit_end already implies EN, so a waiting byte chains straight into the next frame.
                if (bit_end) begin
                    if (hold_full) begin
                        take      = 1'b1;
                        reload    = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (take) begin
            shifter_nxt = hold_data;
        end
    end

    always_comb begin
        TX = IDLE_LEVEL;
        case (state)
            IDLE:    TX = IDLE_LEVEL;
            START:   TX = START_LEVEL;
            DATA:    TX = shifter[0];
            STOP:    TX = STOP_LEVEL;
            default: TX = IDLE_LEVEL;
        endcase
    end

    assign DONE      = (state == STOP) && bit_end;
    assign TXE       = !hold_full;
    assign TXIDLE    = (state == IDLE) && !hold_full;
    assign OVR       = ovr;
    assign state_dbg = state;

endmodule
